seq_gen: RTL and testbench

Serial pattern transmitter: the sending end of the serial bit-stream interface consumed by the team's sequence detectors. It loads a parallel pattern of up to WIDTH bits and shifts it out MSB-first, one bit per clock, repeated a programmable number of times. Output `x` connects directly to a detector's serial input, such as the `111` detector, which lets a bench generate overlapping and non-overlapping detection streams.

---
 rtl/seq_gen.sv | 123 ++++++++++++
 tb/tb_seq_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter, MSB-first, repeated reps times.
// Ports: clk, reset (async active-low), start, abort, pattern, len, reps
//        in; x, x_valid, busy, done out (all registered).
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] sh;

    assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        x_d      = 1'b0;
        xv_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sh       = '0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    shadow_d = pattern;
                    len_d    = len_eff;
                    rep_d    = reps;
                    if (len_eff == '0 || reps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First bit goes out straight from the input so
                        // bit 0 appears in the cycle after start.
                        state_d = SEND;
                        idx_d   = len_eff - LEN_W'(1);
                        sh      = pattern >> idx_d;
                        x_d     = sh[0];
                        xv_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == '0 && rep_q == REP_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    // idx_q tracks the bit currently on x.
                    if (idx_q == '0) begin
                        idx_d = len_q - LEN_W'(1);
                        rep_d = rep_q - REP_W'(1);
                    end else begin
                        idx_d = idx_q - LEN_W'(1);
                    end
                    sh     = shadow_q >> idx_d;
                    x_d    = sh[0];
                    xv_d   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            x_q      <= 1'b0;
            xv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            x_q      <= x_d;
            xv_q     <= xv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed self-checking bench for seq_gen.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seq_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    logic [3:0] outs;
    int         n_chk;
    int         n_fail;

    assign outs = {x, x_valid, busy, done};

    seq_gen #(
        .WIDTH(8),
        .LEN_W(4),
        .REP_W(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .pattern(pattern),
        .len    (len),
        .reps   (reps),
        .x      (x),
        .x_valid(x_valid),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] p, input logic [3:0] l,
                              input logic [3:0] r);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Expects bits[n-1] first, then the done cycle; no tick after done.
    task automatic chk_stream(input string tag, input logic [15:0] bits,
                              input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(outs),
                  32'({bits[n-1-i], 3'b110}));
            tick();
        end
        check({tag, "_done"}, 32'(outs), 32'h1);
    endtask

    logic [2:0] hist;
    int         dets;
    logic [7:0] fr;

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        fr      = 8'b1011_0010;

        // reset and idle hold
        tick();
        tick();
        check("rst_outs", 32'(outs), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle_%0d", i), 32'(outs), 32'h0);
        end

        // single frame
        start_xfer(fr, 4'd8, 4'd1);
        chk_stream("frame", 16'(fr), 8);
        tick();
        check("frame_after", 32'(outs), 32'h0);

        // overlap stream into a 111 detector model
        start_xfer(8'b0000_0111, 4'd3, 4'd2);
        hist = '0;
        dets = 0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ovl_b%0d", i), 32'(outs), 32'hE);
            hist = {hist[1:0], x & x_valid};
            if (&hist) dets++;
            check($sformatf("ovl_det%0d", i), 32'(&hist),
                  32'(i >= 2));
            tick();
        end
        check("ovl_dets", 32'(dets), 32'd4);
        check("ovl_done", 32'(outs), 32'h1);
        tick();

        // start during SEND is ignored
        start_xfer(fr, 4'd8, 4'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ign_b%0d", i), 32'(outs),
                  32'({fr[7-i], 3'b110}));
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("ign_done", 32'(outs), 32'h1);
        tick();
        check("ign_no_restart", 32'(outs), 32'h0);

        // abort at bit 2, then start at the very next edge
        start_xfer(fr, 4'd8, 4'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abt_b%0d", i), 32'(outs),
                  32'({fr[7-i], 3'b110}));
            if (i == 2) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        check("abt_outs", 32'(outs), 32'h0);
        start_xfer(8'h0A, 4'd4, 4'd1);
        chk_stream("post_abt", 16'hA, 4);
        tick();
        check("post_abt_after", 32'(outs), 32'h0);

        // abort in IDLE blocks a simultaneous start
        abort = 1'b1;
        start_xfer(fr, 4'd8, 4'd1);
        abort = 1'b0;
        check("idle_abort", 32'(outs), 32'h0);

        // degenerate transfers
        start_xfer(fr, 4'd8, 4'd0);
        check("reps0_done", 32'(outs), 32'h1);
        tick();
        check("reps0_after", 32'(outs), 32'h0);
        start_xfer(fr, 4'd0, 4'd3);
        check("len0_done", 32'(outs), 32'h1);
        tick();
        check("len0_after", 32'(outs), 32'h0);

        // len clamps to WIDTH
        start_xfer(fr, 4'd12, 4'd1);
        chk_stream("clamp", 16'(fr), 8);
        tick();

        // three repetitions, then back-to-back start in the done cycle
        start_xfer(8'b10, 4'd2, 4'd3);
        chk_stream("rep3", 16'b10_1010, 6);
        start_xfer(8'b01, 4'd2, 4'd1);
        chk_stream("b2b", 16'b01, 2);
        tick();

        // asynchronous reset mid-frame at bit 4
        start_xfer(fr, 4'd8, 4'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("arst_b%0d", i), 32'(outs),
                  32'({fr[7-i], 3'b110}));
            if (i < 4) tick();
        end
        #2;
        reset = 1'b0;
        #1;
        check("arst_async", 32'(outs), 32'h0);
        tick();
        check("arst_hold", 32'(outs), 32'h0);
        reset = 1'b1;
        start_xfer(fr, 4'd8, 4'd1);
        chk_stream("arst_fresh", 16'(fr), 8);
        tick();
        check("arst_end", 32'(outs), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
